// File: rtl/alu_seq_exec.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_exec
// Description : Execute-stage ALU. Logic, arithmetic, compare, branch and
//               jump ops complete in one cycle. Shifts go through a serial
//               one-bit-per-cycle shifter, so issue sees a valid/ready
//               handshake and writeback sees a one-cycle valid_o pulse.
// Ports       : clk_i, rst_i      - clock, synchronous active-high reset
//               valid_i, ready_o  - issue handshake (accept on both high)
//               op_i              - 5-bit ALU control code
//               a_i, b_i          - operands (b_i[4:0] is shift amount)
//               kill_i            - abort an in-flight shift
//               valid_o           - one-cycle result pulse
//               result_o, branch_o- registered result and branch-taken flag
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_exec #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            kill_i,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            branch_o
);

    // FSM encoding
    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_shift = 1'b1;

    // Shift direction/fill kinds
    localparam logic [1:0] c_kind_sll = 2'd0;
    localparam logic [1:0] c_kind_srl = 2'd1;
    localparam logic [1:0] c_kind_sra = 2'd2;

    // Operation codes
    localparam logic [4:0] c_op_add  = 5'b00000;
    localparam logic [4:0] c_op_sll  = 5'b00001;
    localparam logic [4:0] c_op_slt  = 5'b00010;
    localparam logic [4:0] c_op_sltu = 5'b00011;
    localparam logic [4:0] c_op_xor  = 5'b00100;
    localparam logic [4:0] c_op_srl  = 5'b00101;
    localparam logic [4:0] c_op_or   = 5'b00110;
    localparam logic [4:0] c_op_and  = 5'b00111;
    localparam logic [4:0] c_op_sub  = 5'b01000;
    localparam logic [4:0] c_op_sra  = 5'b01101;
    localparam logic [4:0] c_op_beq  = 5'b10000;
    localparam logic [4:0] c_op_bne  = 5'b10001;
    localparam logic [4:0] c_op_blt  = 5'b10100;
    localparam logic [4:0] c_op_bge  = 5'b10101;
    localparam logic [4:0] c_op_bltu = 5'b10110;
    localparam logic [4:0] c_op_bgeu = 5'b10111;
    localparam logic [4:0] c_op_jal  = 5'b11111;

    logic [0:0]      r_state;
    logic [4:0]      r_cnt;
    logic [XLEN-1:0] r_acc;
    logic [1:0]      r_kind;
    logic            r_valid;
    logic [XLEN-1:0] r_result;
    logic            r_branch;

    logic            w_accept;
    logic            w_is_shift;
    logic [1:0]      w_kind;
    logic [XLEN-1:0] w_res;
    logic            w_br;
    logic            w_lt_s;
    logic            w_lt_u;
    logic            w_eq;
    logic [4:0]      w_amt;

    // One step of the serial shifter; SRA replicates the sign bit.
    function automatic logic [XLEN-1:0] f_step(input logic [1:0] kind,
                                               input logic [XLEN-1:0] v);
        logic [XLEN-1:0] s;
        case (kind)
            c_kind_srl: s = {1'b0, v[XLEN-1:1]};
            c_kind_sra: s = {v[XLEN-1], v[XLEN-1:1]};
            default:    s = {v[XLEN-2:0], 1'b0};
        endcase
        return s;
    endfunction

    // ready depends on state only, never on valid_i
    assign ready_o  = (r_state == c_st_idle);
    assign w_accept = valid_i && ready_o;
    assign w_amt    = b_i[4:0];

    assign w_lt_s = $signed(a_i) < $signed(b_i);
    assign w_lt_u = a_i < b_i;
    assign w_eq   = (a_i == b_i);

    // Single-cycle result/branch decode; for shifts w_res is the n=0 result.
    always_comb begin
        w_res      = '0;
        w_br       = 1'b0;
        w_is_shift = 1'b0;
        w_kind     = c_kind_sll;
        case (op_i)
            c_op_add:  w_res = a_i + b_i;
            c_op_sub:  w_res = a_i - b_i;
            c_op_slt:  w_res = {{(XLEN-1){1'b0}}, w_lt_s};
            c_op_sltu: w_res = {{(XLEN-1){1'b0}}, w_lt_u};
            c_op_xor:  w_res = a_i ^ b_i;
            c_op_or:   w_res = a_i | b_i;
            c_op_and:  w_res = a_i & b_i;
            c_op_sll: begin
                w_is_shift = 1'b1;
                w_kind     = c_kind_sll;
                w_res      = a_i;
            end
            c_op_srl: begin
                w_is_shift = 1'b1;
                w_kind     = c_kind_srl;
                w_res      = a_i;
            end
            c_op_sra: begin
                w_is_shift = 1'b1;
                w_kind     = c_kind_sra;
                w_res      = a_i;
            end
            c_op_beq:  w_br = w_eq;
            c_op_bne:  w_br = !w_eq;
            c_op_blt:  w_br = w_lt_s;
            c_op_bge:  w_br = !w_lt_s;
            c_op_bltu: w_br = w_lt_u;
            c_op_bgeu: w_br = !w_lt_u;
            c_op_jal: begin
                w_res = a_i;
                w_br  = 1'b1;
            end
            default: begin
                w_res = '0;
                w_br  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= c_st_idle;
            r_cnt    <= 5'd0;
            r_acc    <= '0;
            r_kind   <= c_kind_sll;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_branch <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    // kill_i is ignored here; an accept proceeds normally
                    if (w_accept) begin
                        if (w_is_shift && (w_amt >= 5'd2)) begin
                            // Accept edge already performs the first step
                            r_acc   <= f_step(w_kind, a_i);
                            r_cnt   <= w_amt - 5'd1;
                            r_kind  <= w_kind;
                            r_state <= c_st_shift;
                        end else begin
                            r_valid  <= 1'b1;
                            r_branch <= w_br;
                            if (w_is_shift && (w_amt == 5'd1))
                                r_result <= f_step(w_kind, a_i);
                            else
                                r_result <= w_res;
                        end
                    end
                end
                c_st_shift: begin
                    if (kill_i) begin
                        // Flush: drop the shift, leave result/branch as is
                        r_state <= c_st_idle;
                        r_cnt   <= 5'd0;
                    end else if (r_cnt == 5'd1) begin
                        r_result <= f_step(r_kind, r_acc);
                        r_branch <= 1'b0;
                        r_valid  <= 1'b1;
                        r_cnt    <= 5'd0;
                        r_state  <= c_st_idle;
                    end else begin
                        r_acc <= f_step(r_kind, r_acc);
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign valid_o  = r_valid;
    assign result_o = r_result;
    assign branch_o = r_branch;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_exec.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_exec
// Description : Self-checking bench for alu_seq_exec. Expected results and
//               their due cycle are queued at accept time and compared when
//               valid_o pulses; directed sections cover handshake timing,
//               kill and mid-shift reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_exec;

    logic        clk_i;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [4:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        kill_i;
    logic        valid_o;
    logic [31:0] result_o;
    logic        branch_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] res;
        logic        br;
        int          due;
    } exp_t;

    exp_t sb[$];

    alu_seq_exec #(.XLEN(32)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .kill_i   (kill_i),
        .valid_o  (valid_o),
        .result_o (result_o),
        .branch_o (branch_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: {branch, result}
    function automatic logic [32:0] ref_op(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] r;
        logic        t;
        r = 32'h0;
        t = 1'b0;
        case (op)
            5'b00000: r = a + b;
            5'b00001: r = a << b[4:0];
            5'b00010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'b00011: r = (a < b) ? 32'd1 : 32'd0;
            5'b00100: r = a ^ b;
            5'b00101: r = a >> b[4:0];
            5'b00110: r = a | b;
            5'b00111: r = a & b;
            5'b01000: r = a - b;
            5'b01101: r = $unsigned($signed(a) >>> b[4:0]);
            5'b10000: t = (a == b);
            5'b10001: t = (a != b);
            5'b10100: t = ($signed(a) < $signed(b));
            5'b10101: t = ($signed(a) >= $signed(b));
            5'b10110: t = (a < b);
            5'b10111: t = (a >= b);
            5'b11111: begin r = a; t = 1'b1; end
            default: begin r = 32'h0; t = 1'b0; end
        endcase
        return {t, r};
    endfunction

    function automatic int ref_lat(input logic [4:0] op, input logic [31:0] b);
        if ((op == 5'b00001 || op == 5'b00101 || op == 5'b01101) && b[4:0] >= 5'd2)
            return int'(b[4:0]);
        return 1;
    endfunction

    // Offer an op, hold it until accepted, optionally queue its expectation.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push);
        logic [32:0] e;
        exp_t        x;
        int          guard;
        valid_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        guard   = 0;
        while (!ready_o && guard < 100) begin
            @(posedge clk_i);
            #1;
            guard++;
        end
        if (guard >= 100) chk("ready_timeout", 32'(ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        if (push) begin
            e     = ref_op(op, a, b);
            x.res = e[31:0];
            x.br  = e[32];
            x.due = cyc - 1 + ref_lat(op, b);
            sb.push_back(x);
        end
    endtask

    // Scoreboard monitor: content, latency, spurious and missing pulses
    always @(negedge clk_i) begin
        exp_t e;
        if (valid_o) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result", result_o, e.res);
                chk("branch", 32'(branch_o), 32'(e.br));
                chk("latency", cyc, e.due);
            end
        end else if (sb.size() > 0 && cyc > sb[0].due) begin
            e = sb.pop_front();
            chk("missing_valid", 32'd0, 32'd1);
        end
    end

    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b0;
        kill_i  = 1'b0;
        op_i    = 5'd0;
        a_i     = 32'd0;
        b_i     = 32'd0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Reset state
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_branch", 32'(branch_o), 32'd0);

        // Wrap-around add, then back-to-back sub
        issue(5'b00000, 32'hFFFF_FFFF, 32'd1, 1'b1);
        issue(5'b01000, 32'd5, 32'd7, 1'b1);
        @(negedge clk_i);
        chk("sub_value", result_o, 32'hFFFF_FFFE);
        @(posedge clk_i);
        #1;

        // SRA by 31: ready low for 30 cycles, result in T+31
        issue(5'b01101, 32'h8000_0000, 32'd31, 1'b1);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk_i);
            chk("sra_ready_low", 32'(ready_o), 32'd0);
        end
        @(negedge clk_i);
        chk("sra_ready_back", 32'(ready_o), 32'd1);
        chk("sra_valid", 32'(valid_o), 32'd1);
        chk("sra_value", result_o, 32'hFFFF_FFFF);
        issue(5'b00001, 32'd1, 32'd0, 1'b1);

        // Branch, compare and jump cases
        issue(5'b10100, 32'hFFFF_FFFF, 32'd1, 1'b1);
        issue(5'b10110, 32'hFFFF_FFFF, 32'd1, 1'b1);
        issue(5'b10000, 32'h1234, 32'h1234, 1'b1);
        issue(5'b00010, 32'h8000_0000, 32'd0, 1'b1);
        issue(5'b00011, 32'h8000_0000, 32'd0, 1'b1);
        issue(5'b11111, 32'h104, 32'd0, 1'b1);
        issue(5'b01010, 32'hDEAD, 32'hBEEF, 1'b1);
        @(negedge clk_i);
        chk("undef_valid", 32'(valid_o), 32'd1);

        // kill_i in IDLE does not block an accept
        kill_i = 1'b1;
        issue(5'b00110, 32'h1234_0000, 32'h0000_5678, 1'b1);
        kill_i = 1'b0;

        // Kill an SRL by 8 in T+3
        issue(5'b01000, 32'h1234_5678, 32'd0, 1'b1);
        issue(5'b00101, 32'h0000_00F0, 32'd8, 1'b0);   // now in T+1
        @(posedge clk_i);
        #1;                                            // T+2
        @(posedge clk_i);
        #1;                                            // T+3
        chk("kill_ready_busy", 32'(ready_o), 32'd0);
        kill_i = 1'b1;
        @(posedge clk_i);
        #1;                                            // T+4
        kill_i = 1'b0;
        chk("kill_ready_back", 32'(ready_o), 32'd1);
        chk("kill_result_held", result_o, 32'h1234_5678);
        issue(5'b00100, 32'h0000_00FF, 32'h0000_000F, 1'b1);
        repeat (7) @(posedge clk_i);
        #1;

        // Reset in the middle of SLL by 5
        issue(5'b00001, 32'd3, 32'd5, 1'b0);           // now in T+1
        @(posedge clk_i);
        #1;                                            // T+2
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;                                            // T+3
        rst_i = 1'b0;
        chk("midrst_ready", 32'(ready_o), 32'd1);
        chk("midrst_result", result_o, 32'd0);
        chk("midrst_branch", 32'(branch_o), 32'd0);
        repeat (8) @(posedge clk_i);
        #1;

        // Random mix including shifts and undefined codes
        for (int i = 0; i < 80; i++) begin
            logic [4:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            rop = 5'($urandom_range(0, 31));
            ra  = $urandom();
            rb  = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom();
            if (i % 5 == 0) rb = ra;
            issue(rop, ra, rb, 1'b1);
        end

        // Drain with a bound
        for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk_i);
        @(negedge clk_i);
        chk("drain", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
